// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} fetch_state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  localparam int unsigned FETCH_QDEPTH = 2;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry shift FIFO of fetched instructions, flush beats push/pop
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);
  fetch_entry_t [FETCH_QDEPTH-1:0] ent_q, ent_d;
  logic [1:0] count_q, count_d, wr_idx;
  logic push_ok;
  always_comb begin
    wr_idx = count_q - {1'b0, pop};
    push_ok = push && wr_idx < 2'(FETCH_QDEPTH);
    ent_d = ent_q;
    if (pop) ent_d[0] = ent_q[1];
    if (push_ok) ent_d[wr_idx[0]] = push_data;
    count_d = flush ? 2'd0 : count_q + {1'b0, push_ok} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q <= '0;
      count_q <= '0;
    end else begin
      ent_q <= ent_d;
      count_q <= count_d;
    end
  end
  assign count = count_q;
  assign head = ent_q[0];
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC owner issuing single-outstanding imem requests into a 2-entry queue
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] fetch_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4,
  output logic [31:0] out_instr,
  input  logic        id_ready
);
  fetch_state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic kill_q, kill_d;
  logic [1:0] count, cnt_after;
  fetch_entry_t head;
  logic outstanding, grant, rsp, push, pop;
  assign outstanding = state_q == WAIT;
  assign out_valid = count != 2'd0;
  assign pop = out_valid & id_ready & ~redirect;
  assign cnt_after = redirect ? 2'd0 : count - {1'b0, pop};
  assign imem_req = state_q == ISSUE && !kill_q &&
                    ({1'b0, cnt_after} + {2'b0, outstanding}) < 3'(FETCH_QDEPTH);
  assign imem_addr = fetch_pc_q;
  assign fetch_pc = fetch_pc_q;
  assign grant = imem_req & imem_gnt;
  assign rsp = outstanding & imem_rvalid;
  assign push = rsp & ~kill_q & ~redirect;
  always_comb begin
    state_d = state_q == IDLE ? ISSUE : grant ? WAIT : rsp ? ISSUE : state_q;
    req_pc_d = grant ? fetch_pc_q : req_pc_q;
    fetch_pc_d = redirect ? redirect_pc :
                 !grant ? fetch_pc_q :
                 pred_taken ? pred_target : fetch_pc_q + 32'd4;
    kill_d = rsp ? 1'b0 : (redirect && (grant || outstanding)) ? 1'b1 : kill_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q <= '0;
      kill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q <= req_pc_d;
      kill_q <= kill_d;
    end
  end
  fetch_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ('{pc: req_pc_q, instr: imem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );
  assign out_pc = out_valid ? head.pc : '0;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc_plus_4 = out_valid ? head.pc + 32'd4 : '0;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed table rows plus randomized traffic against a queue-based reference model
module tb_fetch_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] fetch_pc, pred_target, redirect_pc, imem_addr, imem_rdata;
  logic [31:0] out_pc, out_pc_plus_4, out_instr;
  logic pred_taken, redirect = 1'b0, imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic out_valid, id_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .out_instr(out_instr),
    .id_ready(id_ready)
  );

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic pred_en = 1'b0, pred_rand = 1'b0;
  logic [31:0] pred_src = 32'h104, pred_dst = 32'h200;
  int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0, rmode = 0;
  logic [31:0] r_addr = '0, r_pc = '0;
  logic r_done = 1'b0;

  assign pred_taken = pred_en && (fetch_pc == pred_src || (pred_rand && fetch_pc[4:2] == 3'd5));
  assign pred_target = pred_rand ? fetch_pc + 32'h100 : pred_dst;

  function automatic logic [31:0] next_of(input logic [31:0] a);
    logic hit;
    hit = pred_en && (a == pred_src || (pred_rand && a[4:2] == 3'd5));
    return hit ? (pred_rand ? a + 32'h100 : pred_dst) : a + 32'd4;
  endfunction

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t mq[$];
  logic [31:0] deq_log[$];
  logic pend = 1'b0, pend_kill = 1'b0;
  logic [31:0] pend_addr = '0, exp_pc = 32'h100;
  int pend_due = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; id_ready = 1'b0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_fetch_pc", fetch_pc, 32'h100);
    check("rst_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_pc4", out_pc_plus_4, 0);
    check("rst_instr", out_instr, 0);
    repeat (2) @(negedge clk);
    mq.delete(); deq_log.delete();
    pend = 1'b0; pend_kill = 1'b0; exp_pc = 32'h100; r_done = 1'b0;
    reset = 1'b1;
    #1;
    check("idle_req", imem_req, 0);
  endtask

  task automatic cycle();
    logic rv, gr, dq, req_exp;
    int qa;
    @(negedge clk);
    imem_gnt = $urandom_range(99) < gnt_pct;
    id_ready = $urandom_range(99) < rdy_pct;
    rv = pend && cyc >= pend_due;
    imem_rvalid = rv;
    imem_rdata = rv ? instr_of(pend_addr) : $urandom;
    redirect = 1'b0;
    redirect_pc = $urandom;
    #1;
    if (!r_done && rmode != 0) begin
      if ((rmode == 1 && pend && !rv && pend_addr == r_addr) ||
          (rmode == 2 && imem_req && imem_gnt && imem_addr == r_addr) ||
          (rmode == 3 && rv && pend_addr == r_addr)) begin
        redirect = 1'b1; redirect_pc = r_pc; r_done = 1'b1;
      end
    end else if ($urandom_range(99) < redir_pct) begin
      redirect = 1'b1;
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom_range(3) << 2);
    end
    #1;
    check("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("out_pc", out_pc, mq[0].pc);
      check("out_instr", out_instr, mq[0].instr);
      check("out_pc_plus_4", out_pc_plus_4, mq[0].pc + 32'd4);
    end
    dq = mq.size() != 0 && id_ready && !redirect;
    qa = redirect ? 0 : mq.size() - int'(dq);
    req_exp = !pend && qa < 2;
    check("imem_req", imem_req, req_exp);
    check("fetch_pc", fetch_pc, exp_pc);
    if (req_exp) check("imem_addr", imem_addr, exp_pc);
    gr = req_exp && imem_gnt;
    if (rv && !pend_kill && !redirect) check("rsp_room", mq.size() < 2, 1);
    if (dq) begin
      deq_log.push_back(mq[0].pc);
      void'(mq.pop_front());
    end
    if (rv) begin
      if (!pend_kill && !redirect) mq.push_back('{pend_addr, instr_of(pend_addr)});
      pend = 1'b0;
    end else if (pend && redirect) pend_kill = 1'b1;
    if (gr) begin
      pend = 1'b1; pend_addr = exp_pc; pend_kill = redirect;
      pend_due = cyc + $urandom_range(lat_max, lat_min);
    end
    exp_pc = redirect ? redirect_pc : gr ? next_of(exp_pc) : exp_pc;
    if (redirect) mq.delete();
  endtask

  task automatic check_log(input string name, input int i, input logic [31:0] want);
    if (deq_log.size() <= i) begin
      checks++; errors++;
      $display("FAIL %s[%0d]: got no instruction expected pc %h", name, i, want);
    end else check(name, deq_log[i], want);
  endtask

  typedef struct {
    logic pred;
    int lat;
    int mode;
    logic [31:0] raddr;
    logic [31:0] rpc;
    logic [31:0] pcs[4];
  } vec_t;
  vec_t vt[6];

  initial begin
    vt[0] = '{1'b0, 1, 0, 32'h0,   32'h0,         '{32'h100, 32'h104, 32'h108, 32'h10C}};
    vt[1] = '{1'b1, 1, 0, 32'h0,   32'h0,         '{32'h100, 32'h104, 32'h200, 32'h204}};
    vt[2] = '{1'b0, 2, 1, 32'h108, 32'h300,       '{32'h100, 32'h104, 32'h300, 32'h304}};
    vt[3] = '{1'b0, 1, 2, 32'h10C, 32'h300,       '{32'h100, 32'h104, 32'h300, 32'h304}};
    vt[4] = '{1'b0, 1, 3, 32'h10C, 32'h400,       '{32'h100, 32'h104, 32'h108, 32'h400}};
    vt[5] = '{1'b0, 1, 2, 32'h100, 32'hFFFF_FFF8, '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4}};
    for (int v = 0; v < 6; v++) begin
      pred_en = vt[v].pred; pred_rand = 1'b0; pred_src = 32'h104; pred_dst = 32'h200;
      gnt_pct = 100; rdy_pct = 100; lat_min = vt[v].lat; lat_max = vt[v].lat; redir_pct = 0;
      rmode = vt[v].mode; r_addr = vt[v].raddr; r_pc = vt[v].rpc;
      do_reset();
      repeat (24) cycle();
      for (int i = 0; i < 4; i++) check_log($sformatf("row%0d_pc", v), i, vt[v].pcs[i]);
    end

    rmode = 0; pred_en = 1'b0; lat_min = 1; lat_max = 1; rdy_pct = 0;
    do_reset();
    repeat (8) cycle();
    check("stall_req", imem_req, 0);
    check("stall_valid", out_valid, 1);
    check("stall_head", out_pc, 32'h100);
    rdy_pct = 100;
    repeat (12) cycle();
    check_log("drain_pc", 0, 32'h100);
    check_log("drain_pc", 1, 32'h104);
    check_log("drain_pc", 2, 32'h108);

    pred_en = 1'b1; pred_rand = 1'b1; pred_src = 32'h1;
    gnt_pct = 70; rdy_pct = 70; lat_min = 1; lat_max = 3; redir_pct = 5;
    do_reset();
    repeat (3000) cycle();
    do_reset();
    repeat (2000) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
